// File: rtl/addsub_seq_pkg.sv
// rtl/addsub_seq_pkg.sv - shared types, constants and helpers for addsub_seq
//
// Contents:
//   state_t      : controller states IDLE, RUN, DONE
//   OP_ADD/OP_SUB: encodings of the op input
//   even_parity  : 1 when the operand has an even number of set bits
//                  (operands up to 64 bits; zero-extension keeps parity)
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic logic even_parity(input logic [63:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - CHUNK-bit ripple-carry adder built from full adders
//
// Ports:
//   a, b  : CHUNK-bit addends
//   cin   : carry into bit 0
//   sum   : CHUNK-bit sum
//   cout  : carry out of bit CHUNK-1
//   c_top : carry into bit CHUNK-1 (used for signed overflow)
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_top
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_top = c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle chunked adder/subtractor with status flags
//
// Adds (or, with ADDSUB_SEQ_SUB_EN defined, subtracts) two WIDTH-bit operands
// CHUNK bits per clock. Without ADDSUB_SEQ_SUB_EN, op is ignored and the
// block always adds with carry-in 0.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   x, y, op            : operands and operation (0 add, 1 subtract x - y)
//   out_valid, out_ready: result handshake
//   z                   : registered result
//   S, ZR, CY, P, V     : sign, zero, carry (no-borrow), even parity, overflow
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             S,
    output logic             ZR,
    output logic             CY,
    output logic             P,
    output logic             V
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t state_q, state_d;

    // Operand registers shift right by one chunk per RUN cycle so the adder
    // always sees the current chunk in the low bits.
    logic [WIDTH-1:0] x_q, y_q, acc_q, acc_next;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;

    logic [WIDTH-1:0] y_load;
    logic             cin_load;
    logic [CHUNK-1:0] sum;
    logic             cout, c_top;
    logic             accept, last_chunk;

`ifdef ADDSUB_SEQ_SUB_EN
    assign y_load   = (op == OP_SUB) ? ~y : y;
    assign cin_load = (op == OP_SUB);
`else
    logic unused_op;
    assign unused_op = op;
    assign y_load    = y;
    assign cin_load  = 1'b0;
`endif

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a     (x_q[CHUNK-1:0]),
        .b     (y_q[CHUNK-1:0]),
        .cin   (carry_q),
        .sum   (sum),
        .cout  (cout),
        .c_top (c_top)
    );

    // Each new chunk enters at the top; after NCHUNK cycles the first chunk
    // has been shifted down to bit 0.
    assign acc_next   = (acc_q >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (state_q == RUN) && (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            z         <= '0;
            S         <= 1'b0;
            ZR        <= 1'b0;
            CY        <= 1'b0;
            P         <= 1'b0;
            V         <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            x_q     <= x;
            y_q     <= y_load;
            carry_q <= cin_load;
            idx_q   <= '0;
            acc_q   <= '0;
        end else if (state_q == RUN) begin
            x_q     <= x_q >> CHUNK;
            y_q     <= y_q >> CHUNK;
            acc_q   <= acc_next;
            carry_q <= cout;
            idx_q   <= idx_q + IDX_W'(1);
            if (last_chunk) begin
                z         <= acc_next;
                S         <= acc_next[WIDTH-1];
                ZR        <= (acc_next == '0);
                CY        <= cout;
                P         <= even_parity(64'(acc_next));
                V         <= c_top ^ cout;
                out_valid <= 1'b1;
            end
        end else if ((state_q == DONE) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - self-checking bench for addsub_seq (WIDTH 16, CHUNK 4)
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x, y;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic        S, ZR, CY, P, V;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .S         (S),
        .ZR        (ZR),
        .CY        (CY),
        .P         (P),
        .V         (V)
    );

    typedef struct {
        logic [15:0] z;
        logic        s, zr, cy, p, v;
    } res_t;

    typedef struct {
        logic [15:0] x, y;
        logic        op;
        res_t        e;
    } vec_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    res_t exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic o);
        res_t        r;
        logic [15:0] bb;
        logic        ci;
        logic [16:0] s;
`ifdef ADDSUB_SEQ_SUB_EN
        bb = o ? ~b : b;
        ci = o;
`else
        bb = b;
        ci = o & 1'b0;
`endif
        s    = {1'b0, a} + {1'b0, bb} + 17'(ci);
        r.z  = s[15:0];
        r.s  = s[15];
        r.zr = (s[15:0] == 16'h0);
        r.cy = s[16];
        r.p  = ~(^s[15:0]);
        r.v  = (a[15] == bb[15]) && (s[15] != a[15]);
        return r;
    endfunction

    task automatic check_outputs(input string tag, input res_t e);
        check({tag, "_z"},  32'(z),  32'(e.z));
        check({tag, "_S"},  32'(S),  32'(e.s));
        check({tag, "_ZR"}, 32'(ZR), 32'(e.zr));
        check({tag, "_CY"}, 32'(CY), 32'(e.cy));
        check({tag, "_P"},  32'(P),  32'(e.p));
        check({tag, "_V"},  32'(V),  32'(e.v));
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic o, input res_t e);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_before_offer", 32'(in_ready), 32'd1);
        x = a; y = b; op = o; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); op = 1'($urandom);
    endtask

    task automatic wait_result(input string tag);
        int   lat = 0;
        res_t e;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after"},    32'(in_ready),  32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_t zero_r;
        res_t e;
        zero_r = '{z: 16'h0, s: 1'b0, zr: 1'b0, cy: 1'b0, p: 1'b0, v: 1'b0};

        //                x         y         op    z         S     ZR    CY    P     V
        vecs.push_back('{16'h8FFF, 16'h8000, 1'b0, '{16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{16'h8AFF, 16'h0002, 1'b0, '{16'h8B01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{16'hFFFE, 16'hA000, 1'b0, '{16'h9FFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{16'h8FFF, 16'h7700, 1'b0, '{16'h06FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}});
        vecs.push_back('{16'h0001, 16'hFFFF, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}});
`ifdef ADDSUB_SEQ_SUB_EN
        vecs.push_back('{16'h0000, 16'h0001, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{16'h7FFF, 16'hFFFF, 1'b1, '{16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}});
`else
        vecs.push_back('{16'h0000, 16'h0001, 1'b1, '{16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}});
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = 16'h0; y = 16'h0; op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check_outputs("reset", zero_r);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            offer(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].e);
            wait_result($sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            logic [15:0] a, b;
            logic        o;
            a = 16'($urandom); b = 16'($urandom); o = 1'($urandom);
            offer(a, b, o, model(a, b, o));
            wait_result($sformatf("rnd%0d", i));
            handshake($sformatf("rnd%0d", i));
        end

        // Backpressure: hold the result while a second pair is offered.
        out_ready = 1'b0;
        offer(vecs[0].x, vecs[0].y, vecs[0].op, vecs[0].e);
        wait_result("bp_first");
        x = 16'h1234; y = 16'h1111; op = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_stall%0d_in_ready", c),  32'(in_ready),  32'd0);
            check($sformatf("bp_stall%0d_out_valid", c), 32'(out_valid), 32'd1);
            check_outputs($sformatf("bp_stall%0d", c), vecs[0].e);
        end
        handshake("bp_first");
        @(posedge clk);
        exp_q.push_back(model(16'h1234, 16'h1111, 1'b0));
        #1;
        in_valid = 1'b0;
        wait_result("bp_second");
        check("bp_second_z_const", 32'(z), 32'h2345);
        handshake("bp_second");

        // Asynchronous reset in the middle of RUN.
        offer(16'h1234, 16'h4321, 1'b0, model(16'h1234, 16'h4321, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check_outputs("midrst", zero_r);
        @(posedge clk); #1;
        check("midrst_hold_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        e = '{z: 16'h0007, s: 1'b0, zr: 1'b0, cy: 1'b0, p: 1'b0, v: 1'b0};
        offer(16'h0003, 16'h0004, 1'b0, e);
        wait_result("post_rst");
        handshake("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised multi-cycle adder/subtractor that replaces the fixed 16-bit ripple adder datapath with a chunked, handshaked unit. It adds (or subtracts) two WIDTH-bit operands CHUNK bits per clock. It produces the same five status flags as the existing adder: sign, zero, carry, parity and overflow. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK, minimum 4
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and op are valid
- in_ready  out  1  block can accept operands; combinational, high exactly in IDLE
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- op  in  1  0 = add, 1 = subtract (x − y); see Configuration
- out_valid  out  1  z and flags hold a completed result
- out_ready  in  1  consumer accepts the result
- z  out  WIDTH  result, registered
- S  out  1  sign flag, z[WIDTH-1]
- ZR  out  1  zero flag, z == 0
- CY  out  1  carry out of the MSB; for subtract, 1 means no borrow
- P  out  1  even parity, 1 when popcount(z) is even
- V  out  1  signed overflow, carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid: latch x, latch y' = (op ? ~y : y), set carry = op, set idx = 0, go to RUN.
- **RUN:**
  - Each cycle adds chunk idx of x and y' plus carry into an internal accumulator, then stores the chunk carry-out.
  - in_ready = 0; in_valid is ignored.
  - On the last chunk (idx = NCHUNK−1), capture the carry into the top bit as well.
  - At that same edge, load z, S, ZR, CY, P and V from the final values, set out_valid = 1, go to DONE.
- **DONE:**
  - out_valid = 1; z and flags are held stable.
  - On out_ready: clear out_valid, go to IDLE.
  - z and flags keep their last value until the next result is loaded.
- No overlap between transactions: a new operand pair is accepted only in IDLE.
- Arithmetic is modulo 2^WIDTH. Carry out of the MSB goes to CY only.
- **Reset (asynchronous, any state, including mid-RUN):**
  - Go to IDLE; out_valid = 0.
  - z, S, ZR, CY, P, V = 0; accumulator, carry and idx = 0.
  - in_ready = 1 once in IDLE.
  - A partial result is never presented after reset.

## Timing
- The accepting edge is the edge where in_valid && in_ready.
- out_valid rises NCHUNK edges after the accepting edge (4 for the default parameters).
- The earliest next acceptance is the edge after the out_ready handshake. Throughput is therefore one result per NCHUNK+2 cycles with out_ready held high.
- Holding out_ready = 0 stalls indefinitely in DONE; outputs must not change.
- x, y and op only need to be valid at the accepting edge.

## Configuration
- ADDSUB_SEQ_SUB_EN
- Defined: op selects add or subtract as described above.
- Undefined: op is ignored, the block always adds (carry-in 0), and the inversion logic is not synthesised.

## Structure
- Shared package addsub_seq_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the OP_ADD / OP_SUB constants;
  - a parity function.
- Sub-module chunk_adder: CHUNK-bit ripple adder built from full adders.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_top (carry into bit CHUNK−1), which is needed for V.
- The top level holds the FSM, idx counter, operand/accumulator registers and flag logic.

## Test plan
All scenarios use WIDTH = 16, CHUNK = 4, out_ready = 1 unless noted.
- 8FFF + 8000 → z = 0FFF, CY = 1, V = 1, S = 0, ZR = 0, P = 1; out_valid is high 4 edges after acceptance.
- AAAA + 5555 → FFFF, S = 1, CY = 0, V = 0, P = 1. 8AFF + 0002 → 8B01, S = 1, P = 0, CY = 0, V = 0.
- FFFE + A000 → 9FFE, CY = 1, V = 0, S = 1. 8FFF + 7700 → 06FF, CY = 1, V = 0. 0001 + FFFF → 0000, ZR = 1, CY = 1, P = 1.
- Backpressure: out_ready = 0 for 3 cycles in DONE while a second pair is offered.
  - Required: in_ready = 0, z and flags are stable, and the second pair is accepted only after the handshake.
- Reset: pull rst_n low after 2 RUN cycles.
  - Required: out_valid = 0, all outputs are 0 and in_ready = 1 immediately.
  - A new pair 0003 + 0004 then yields 0007.
- With ADDSUB_SEQ_SUB_EN: 0000 − 0001 → FFFF, CY = 0, S = 1.
  - 7FFF − FFFF → 8000, V = 1.
  - Without the macro, op = 1 on 0000, 0001 → 0001.
